// File: rtl/b13_pkg.sv
// Shared types and defaults for the b13 transmit scheduler.
// Holds the transmit FSM encoding and the round-robin index helper.
package b13_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int DEF_NUM_CH    = 4;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_BIT_TICKS = 104;

    // Channel index reached by stepping 'off' places from 'base', wrapping at n.
    function automatic int rr_index(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/b13_tx_scheduler_if.sv
// Requester/line bundle of the b13 transmit scheduler.
// master = channel logic and line driver side, slave = the scheduler.
interface b13_tx_scheduler_if
    import b13_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DATA_W = DEF_DATA_W
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]        req;
    logic [NUM_CH*DATA_W-1:0] req_data;
    logic                     dsr;
    logic [NUM_CH-1:0]        gnt;
    logic [CH_W-1:0]          cur_ch;
    logic                     busy;
    logic                     txd;
    logic                     tx_end;

    modport master (
        output req, req_data, dsr,
        input  gnt, cur_ch, busy, txd, tx_end
    );

    modport slave (
        input  req, req_data, dsr,
        output gnt, cur_ch, busy, txd, tx_end
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requesting channel at or after ptr,
// wrapping past the top index.
module rr_arbiter
    import b13_pkg::*;
#(
    parameter  int NUM_CH = DEF_NUM_CH,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [CH_W-1:0]   winner,
    output logic              valid
);

    // Walk from the farthest offset down so the nearest request is written last.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[rr_index(int'(ptr), i, NUM_CH)]) begin
                winner = CH_W'(rr_index(int'(ptr), i, NUM_CH));
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/b13_tx_scheduler.sv
// Round-robin scheduler sharing one b13 serial transmitter among NUM_CH channels.
// Grants one request per frame and shifts it out as start, LSB-first data, stop.
module b13_tx_scheduler
    import b13_pkg::*;
#(
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BIT_TICKS = DEF_BIT_TICKS
) (
    input logic               clock,
    input logic               reset_n,
    b13_tx_scheduler_if.slave bus
);

    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TICK_W = $clog2(BIT_TICKS);
    localparam int BC_W   = $clog2(DATA_W + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BIT_TICKS - 1);
    localparam logic [BC_W-1:0]   BIT_LAST  = BC_W'(DATA_W - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);

    tx_state_e           state_q, state_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_CH-1:0]   gnt_q, gnt_d;
    logic [CH_W-1:0]     cur_ch_q, cur_ch_d;
    logic                busy_q, busy_d;
    logic                txd_q, txd_d;
    logic                tx_end_q, tx_end_d;

    logic [CH_W-1:0]     arb_winner;
    logic                arb_valid;
    logic [DATA_W-1:0]   win_byte;
    logic [NUM_CH-1:0]   win_onehot;
    logic                tick_last;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req    (bus.req),
        .ptr    (rr_ptr_q),
        .winner (arb_winner),
        .valid  (arb_valid)
    );

    always_comb begin
        win_byte   = '0;
        win_onehot = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (arb_winner == CH_W'(k)) begin
                win_byte      = bus.req_data[k*DATA_W +: DATA_W];
                win_onehot[k] = 1'b1;
            end
        end
    end

    assign tick_last = (tick_q == TICK_LAST);

    // NOTE: every variable gets a default before the case; any branch that skipped one would infer a latch.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_d     = '0;
        cur_ch_d  = cur_ch_q;
        busy_d    = busy_q;
        txd_d     = txd_q;

        unique case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (bus.dsr && arb_valid) begin
                    gnt_d    = win_onehot;
                    cur_ch_d = arb_winner;
                    shreg_d  = win_byte;
                    txd_d    = 1'b0;
                    busy_d   = 1'b1;
                    tick_d   = '0;
                    state_d  = START;
                    rr_ptr_d = (arb_winner == CH_LAST) ? '0 : arb_winner + 1'b1;
                end
            end
            START: begin
                if (tick_last) begin
                    tick_d    = '0;
                    bit_cnt_d = '0;
                    txd_d     = shreg_q[0];
                    state_d   = DATA;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            DATA: begin
                if (tick_last) begin
                    tick_d    = '0;
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
                        txd_d   = 1'b1;
                        state_d = STOP;
                    end else begin
                        txd_d = shreg_d[0];
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            STOP: begin
                if (tick_last) begin
                    tick_d  = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered tx_end must be set one edge early to land on the last stop cycle.
        tx_end_d = (state_d == STOP) && (tick_d == TICK_LAST);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            rr_ptr_q  <= '0;
            gnt_q     <= '0;
            cur_ch_q  <= '0;
            busy_q    <= 1'b0;
            txd_q     <= 1'b1;
            tx_end_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            rr_ptr_q  <= rr_ptr_d;
            gnt_q     <= gnt_d;
            cur_ch_q  <= cur_ch_d;
            busy_q    <= busy_d;
            txd_q     <= txd_d;
            tx_end_q  <= tx_end_d;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.cur_ch = cur_ch_q;
    assign bus.busy   = busy_q;
    assign bus.txd    = txd_q;
    assign bus.tx_end = tx_end_q;

endmodule
